// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared rv32 pipeline widths, constants and the fetch beat type
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_nxt;
        logic [XLEN-1:0] instr;
    } fetch_beat_t;

endpackage

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - pointer, occupancy and flush bookkeeping for a DEPTH-entry queue
module sync_fifo_ctrl #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    // Handshake flags come only from registered count, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode decoupling queue with branch flush
module if_id_queue
    import rv32_pkg::*;
#(
    parameter int XLEN  = rv32_pkg::XLEN,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_pc_nxt,
    input  logic [XLEN-1:0]  in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pc_nxt,
    output logic [XLEN-1:0]  out_instr,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fetch_beat_t      mem [DEPTH];
    fetch_beat_t      head;

    sync_fifo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Entries are not reset; stale contents are hidden by masking the head below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, pc_nxt: in_pc_nxt, instr: in_instr};
        end
    end

    assign head       = mem[rd_ptr];
    assign out_pc     = out_valid ? head.pc     : '0;
    assign out_pc_nxt = out_valid ? head.pc_nxt : '0;
    assign out_instr  = out_valid ? head.instr  : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;
    import rv32_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_pc_nxt;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_pc_nxt;
    logic [31:0]      out_instr;
    logic             flush;
    logic [CNT_W-1:0] count;

    int n_vec = 0;
    int n_bad = 0;

    if_id_queue #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_pc_nxt  (in_pc_nxt),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_pc_nxt (out_pc_nxt),
        .out_instr  (out_instr),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return NOP_INSTR | (pc << 20);
    endfunction

    task automatic drive(input logic [31:0] pc);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_pc_nxt = pc + 32'd1;
        in_instr  = instr_of(pc);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_pc     = '0;
        in_pc_nxt = '0;
        in_instr  = '0;
    endtask

    logic [31:0] sb[$];
    logic [31:0] next_pc;
    int          sent;
    int          cyc;
    logic        do_push;
    logic        do_pop;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle();

        // 1: reset then a single beat
        tick(); tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_pc = 32'd1; in_pc_nxt = 32'd2; in_instr = 32'h02040293;
        #1;
        chk("no_bypass", 32'(out_valid), 32'd0);
        tick();
        idle();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_pc", out_pc, 32'd1);
        chk("t1_pc_nxt", out_pc_nxt, 32'd2);
        chk("t1_instr", out_instr, 32'h02040293);
        chk("t1_count1", 32'(count), 32'd1);
        tick();
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_empty", 32'(out_valid), 32'd0);

        // 2: fill, stall, then drain in order
        out_ready = 1'b0;
        drive(32'd1); tick();
        drive(32'd2); tick();
        drive(32'd3);
        chk("t2_full_count", 32'(count), 32'd2);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_stall_pc", out_pc, 32'd1);
            chk("t2_stall_count", 32'(count), 32'd2);
        end
        out_ready = 1'b1;
        chk("t2_head1", out_pc, 32'd1);
        tick();
        chk("t2_pop_no_push_count", 32'(count), 32'd1);
        chk("t2_head2", out_pc, 32'd2);
        chk("t2_in_ready_back", 32'(in_ready), 32'd1);
        tick();
        idle();
        chk("t2_head3", out_pc, 32'd3);
        chk("t2_head3_instr", out_instr, instr_of(32'd3));
        chk("t2_count_pp", 32'(count), 32'd1);
        tick();
        chk("t2_drained", 32'(count), 32'd0);

        // 3: streaming at count=1
        drive(32'd4); tick();
        for (int p = 5; p <= 9; p++) begin
            drive(32'(p));
            chk("t3_pc", out_pc, 32'(p - 1));
            chk("t3_count", 32'(count), 32'd1);
            tick();
        end
        idle();
        chk("t3_pc_last", out_pc, 32'd9);
        chk("t3_pc_nxt_last", out_pc_nxt, 32'd10);
        tick();
        chk("t3_drained", 32'(count), 32'd0);

        // 4: flush while full with an incoming beat
        out_ready = 1'b0;
        drive(32'd5); tick();
        drive(32'd6); tick();
        drive(32'd7); flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; idle(); out_ready = 1'b0;
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_pc_masked", out_pc, 32'd0);
        drive(32'd20); tick(); idle();
        chk("t4_after_valid", 32'(out_valid), 32'd1);
        chk("t4_after_pc", out_pc, 32'd20);
        chk("t4_after_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t4_no_pc7", 32'(count), 32'd0);

        // 5: reset mid-operation beats flush and push
        out_ready = 1'b0;
        drive(32'd30); tick();
        drive(32'd31); tick();
        chk("t5_pre_count", 32'(count), 32'd2);
        drive(32'd32); flush = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; idle();
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_pc", out_pc, 32'd0);
        chk("t5_pc_nxt", out_pc_nxt, 32'd0);
        chk("t5_instr", out_instr, 32'd0);

        // 6: wrap-around with random decode stalls against a scoreboard
        void'($urandom(32'd1234));
        next_pc = 32'd100;
        sent = 0;
        cyc = 0;
        while ((sent < 3 * DEPTH + 1 || sb.size() != 0) && cyc < 200) begin
            if (sent < 3 * DEPTH + 1) drive(next_pc);
            else idle();
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("t6_in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
            chk("t6_out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("t6_pc", out_pc, sb[0]);
                chk("t6_instr", out_instr, instr_of(sb[0]));
            end
            do_push = in_valid && (sb.size() != DEPTH);
            do_pop  = out_ready && (sb.size() != 0);
            tick();
            if (do_pop) void'(sb.pop_front());
            if (do_push) begin
                sb.push_back(next_pc);
                next_pc = next_pc + 32'd1;
                sent++;
            end
            cyc++;
        end
        idle();
        chk("t6_timeout", 32'(cyc < 200), 32'd1);
        chk("t6_all_sent", 32'(sent), 32'(3 * DEPTH + 1));
        chk("t6_final_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
